// File: rtl/coders_pkg.sv
// Shared 8b/10b constants: comma prefixes, K28.5 symbols and the aligner state type.
package coders_pkg;

  localparam logic [6:0] COMMA_P   = 7'b0011111;
  localparam logic [6:0] COMMA_N   = 7'b1100000;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    UNLOCKED,
    CANDIDATE,
    LOCKED
  } align_state_t;

  // A comma is recognised by its first seven bits only, so K28.1/5/7 all match.
  function automatic logic isCommaPrefix(input logic [9:0] sym);
    return (sym[9:3] == COMMA_P) || (sym[9:3] == COMMA_N);
  endfunction

endpackage

// File: rtl/comma_detect_20b.sv
// Combinational comma search over the ten candidate symbol positions of a 20-bit window.
module comma_detect_20b
  import coders_pkg::*;
(
  input  logic [19:0] i_window,
  output logic [9:0]  o_hit,
  output logic [3:0]  o_detOff,
  output logic        o_commaAny
);

  always_comb begin
    o_hit = '0;
    for (int k = 0; k < 10; k++) begin
      o_hit[k] = isCommaPrefix(i_window[19-k -: 10]);
    end
  end

  // Scanning downwards lets the lowest hit overwrite any higher one.
  always_comb begin
    o_detOff = '0;
    for (int k = 9; k >= 0; k--) begin
      if (o_hit[k]) begin
        o_detOff = 4'(k);
      end
    end
  end

  assign o_commaAny = |o_hit;

endmodule

// File: rtl/comma_aligner_10b.sv
// Word aligner: finds the comma boundary in an unaligned 10-bit stream and emits aligned symbols.
module comma_aligner_10b
  import coders_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [9:0] i_10b,
  output logic       o_valid,
  output logic [9:0] o_10b,
  output logic       o_comma,
  output logic       o_locked,
  output logic [3:0] o_offset,
  output logic       o_realign
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  align_state_t     r_state;
  logic [9:0]       r_prev;
  logic [3:0]       r_off;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_miss;
  logic             r_valid;
  logic [9:0]       r_10b;
  logic             r_comma;
  logic             r_realign;

  logic [19:0]      w_window;
  logic [9:0]       w_hit;
  logic [3:0]       w_detOff;
  logic             w_commaAny;
  logic [3:0]       w_selOff;
  logic [9:0]       w_selSym;
  logic             w_hitAtOff;

  assign w_window = {r_prev, i_10b};

  comma_detect_20b u_detect (
    .i_window   (w_window),
    .o_hit      (w_hit),
    .o_detOff   (w_detOff),
    .o_commaAny (w_commaAny)
  );

  // While unlocked a fresh comma is honoured in the same word it appears in.
  assign w_selOff = (r_state == UNLOCKED && w_commaAny) ? w_detOff : r_off;

  always_comb begin
    w_selSym   = '0;
    w_hitAtOff = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (w_selOff == 4'(k)) begin
        w_selSym = w_window[19-k -: 10];
      end
      if (r_off == 4'(k)) begin
        w_hitAtOff = w_hit[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= UNLOCKED;
      r_prev    <= '0;
      r_off     <= '0;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_valid   <= 1'b0;
      r_10b     <= '0;
      r_comma   <= 1'b0;
      r_realign <= 1'b0;
    end else begin
      r_valid   <= i_valid;
      r_realign <= 1'b0;
      if (i_valid) begin
        r_prev  <= i_10b;
        r_10b   <= w_selSym;
        r_comma <= isCommaPrefix(w_selSym);
        case (r_state)
          UNLOCKED: begin
            if (w_commaAny) begin
              r_off     <= w_detOff;
              r_realign <= (w_detOff != r_off);
              if (LOCK_CNT == 1) begin
                r_state <= LOCKED;
                r_cnt   <= '0;
              end else begin
                r_state <= CANDIDATE;
                r_cnt   <= CNT_ONE;
              end
            end
          end
          CANDIDATE: begin
            if (w_hitAtOff) begin
              if (int'(r_cnt) + 1 == LOCK_CNT) begin
                r_state <= LOCKED;
                r_cnt   <= '0;
              end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end else if (w_commaAny) begin
              r_off     <= w_detOff;
              r_realign <= (w_detOff != r_off);
              r_cnt     <= CNT_ONE;
            end
          end
          LOCKED: begin
            // The offset is frozen here; only a run of foreign commas can break lock.
            if (w_hitAtOff) begin
              r_miss <= '0;
            end else if (w_commaAny) begin
              if (int'(r_miss) + 1 == UNLOCK_CNT) begin
                r_state <= UNLOCKED;
                r_miss  <= '0;
              end else if (r_miss != CNT_SAT) begin
                r_miss <= r_miss + CNT_ONE;
              end
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_10b     = r_10b;
  assign o_comma   = r_comma;
  assign o_locked  = (r_state == LOCKED);
  assign o_offset  = r_off;
  assign o_realign = r_realign;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Self-checking bench for comma_aligner_10b: directed scenarios plus random words against a bit-level model.
module tb_comma_aligner_10b;
  import coders_pkg::*;

  localparam logic [9:0] SYM_C  = K28_5_RDN;
  localparam logic [9:0] SYM_F  = 10'b1010101010;
  localparam int         LOCK   = 3;
  localparam int         UNLOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [9:0] i_10b = '0;
  logic       o_valid;
  logic [9:0] o_10b;
  logic       o_comma;
  logic       o_locked;
  logic [3:0] o_offset;
  logic       o_realign;

  always #5 clk = ~clk;

  comma_aligner_10b #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_10b     (i_10b),
    .o_valid   (o_valid),
    .o_10b     (o_10b),
    .o_comma   (o_comma),
    .o_locked  (o_locked),
    .o_offset  (o_offset),
    .o_realign (o_realign)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: mode 0 = searching, 1 = counting a candidate, 2 = locked.
  logic [9:0] mPrev, m10b;
  logic [3:0] mOff;
  logic       mValid, mComma, mRealign;
  int         mMode, mCnt, mMiss;

  bit         bq[$];
  logic [9:0] recQ[$];
  logic [9:0] obsAll[$];
  logic [9:0] obsAligned[$];
  logic [9:0] symQ[$];
  bit         recOn = 0;
  bit         capOn = 0;
  int         vCount, lockAt, nRealign;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPrev = '0; m10b = '0; mOff = '0;
    mValid = 0; mComma = 0; mRealign = 0;
    mMode = 0; mCnt = 0; mMiss = 0;
  endtask

  task automatic modelStep(input logic v, input logic [9:0] word);
    logic [19:0] w;
    logic [9:0]  sym [10];
    bit          isC [10];
    int          det, sel;
    logic [3:0]  newOff;
    if (!v) begin
      mValid = 0;
      mRealign = 0;
      return;
    end
    w = {mPrev, word};
    det = -1;
    for (int k = 0; k < 10; k++) begin
      sym[k] = 10'((w >> (10 - k)) & 20'h3FF);
      isC[k] = (sym[k][9:3] == COMMA_P) || (sym[k][9:3] == COMMA_N);
      if (isC[k] && det < 0) det = k;
    end
    sel = (mMode == 0 && det >= 0) ? det : int'(mOff);
    m10b = sym[sel];
    mComma = isC[sel];
    mValid = 1;
    newOff = mOff;
    case (mMode)
      0: if (det >= 0) begin newOff = 4'(det); mCnt = 1; mMode = (LOCK == 1) ? 2 : 1; end
      1: begin
        if (isC[mOff]) begin
          if (mCnt + 1 == LOCK) begin mMode = 2; mCnt = 0; end
          else mCnt++;
        end else if (det >= 0) begin
          newOff = 4'(det); mCnt = 1;
        end
      end
      default: begin
        if (isC[mOff]) mMiss = 0;
        else if (det >= 0) begin
          if (mMiss + 1 == UNLOCK) begin mMode = 0; mMiss = 0; end
          else mMiss++;
        end
      end
    endcase
    mRealign = (newOff != mOff);
    mOff = newOff;
    mPrev = word;
  endtask

  task automatic checkOutput();
    checkVal("o_valid",   32'(o_valid),   32'(mValid));
    checkVal("o_10b",     32'(o_10b),     32'(m10b));
    checkVal("o_comma",   32'(o_comma),   32'(mComma));
    checkVal("o_locked",  32'(o_locked),  32'(mMode == 2));
    checkVal("o_offset",  32'(o_offset),  32'(mOff));
    checkVal("o_realign", 32'(o_realign), 32'(mRealign));
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] word);
    i_valid = v;
    i_10b   = word;
    @(posedge clk);
    modelStep(v, word);
    #1;
    checkOutput();
    if (o_valid) begin
      vCount++;
      obsAll.push_back(o_10b);
    end
    if (o_locked && lockAt < 0) lockAt = vCount;
    if (o_realign) begin
      nRealign++;
      capOn = 1;
    end
    if (capOn && o_valid) obsAligned.push_back(o_10b);
    if (recOn && mValid) recQ.push_back(m10b);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_valid = 1'($urandom);
    i_10b = 10'($urandom);
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    i_10b = 10'($urandom);
    vCount = 0; lockAt = -1; nRealign = 0; capOn = 0;
    obsAll.delete(); obsAligned.delete(); bq.delete();
  endtask

  task automatic pushSym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bq.push_back(s[i]);
  endtask

  task automatic pushFill(input int n);
    for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
  endtask

  task automatic sendWords(input int gapPct);
    logic [9:0] word;
    while (bq.size() >= 10) begin
      for (int i = 0; i < 10; i++) word[9-i] = bq.pop_front();
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++) applyStimulus(1'b0, 10'($urandom));
      applyStimulus(1'b1, word);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    vCount = 0; lockAt = -1; nRealign = 0;

    // Reset values, then idle cycles with i_valid low.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 10'($urandom));

    // Aligned commas at offset 0; the comma shows on o_10b once it sits in the previous word.
    doReset();
    recOn = 1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, (i % 2 == 0 && i < 6) ? SYM_C : SYM_F);
      if (i % 2 == 1) begin
        checkVal("s2_comma_sym", 32'(o_10b), 32'(SYM_C));
        checkVal("s2_comma_flag", 32'(o_comma), 32'd1);
      end
    end
    recOn = 0;
    checkVal("s2_locked", 32'(o_locked), 32'd1);
    checkVal("s2_offset", 32'(o_offset), 32'd0);
    checkVal("s2_lock_point", 32'(lockAt), 32'd6);

    // Same symbols shifted by three bits.
    doReset();
    symQ.delete();
    for (int i = 0; i < 3; i++) bq.push_back(1'($urandom));
    for (int i = 0; i < 8; i++) begin
      symQ.push_back((i % 2 == 0) ? SYM_C : SYM_F);
      pushSym((i % 2 == 0) ? SYM_C : SYM_F);
    end
    pushFill(7);
    sendWords(0);
    checkVal("s3_offset", 32'(o_offset), 32'd3);
    checkVal("s3_locked", 32'(o_locked), 32'd1);
    checkVal("s3_realign_count", 32'(nRealign), 32'd1);
    checkVal("s3_sym_count", 32'(obsAligned.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < obsAligned.size(); i++) checkVal("s3_sym", 32'(obsAligned[i]), 32'(symQ[i]));

    // Locked at 0, four foreign commas at offset 7 drop lock.
    doReset();
    for (int i = 0; i < 3; i++) begin pushSym(SYM_C); pushSym(SYM_F); end
    pushSym(SYM_F);
    sendWords(0);
    checkVal("s4_locked_before", 32'(o_locked), 32'd1);
    pushFill(7);
    for (int i = 0; i < 4; i++) begin pushSym(SYM_C); pushSym(SYM_F); end
    pushSym(SYM_F); pushSym(SYM_F);
    sendWords(0);
    checkVal("s4_unlocked", 32'(o_locked), 32'd0);

    // Three foreign commas, one home comma clears the miss count, three more foreign keep lock.
    doReset();
    for (int i = 0; i < 3; i++) begin pushSym(SYM_C); pushSym(SYM_F); end
    pushSym(SYM_F);
    pushFill(7);
    for (int i = 0; i < 3; i++) begin pushSym(SYM_C); pushSym(SYM_F); end
    pushFill(3);
    pushSym(SYM_C); pushSym(SYM_F);
    pushFill(7);
    for (int i = 0; i < 3; i++) begin pushSym(SYM_C); pushSym(SYM_F); end
    pushSym(SYM_F); pushSym(SYM_F);
    sendWords(0);
    checkVal("s4_still_locked", 32'(o_locked), 32'd1);
    checkVal("s4_offset_kept", 32'(o_offset), 32'd0);

    // Scenario 2 again with random idle gaps.
    doReset();
    for (int i = 0; i < 7; i++) pushSym((i % 2 == 0 && i < 6) ? SYM_C : SYM_F);
    sendWords(50);
    checkVal("s5_out_count", 32'(obsAll.size()), 32'(recQ.size()));
    for (int i = 0; i < recQ.size() && i < obsAll.size(); i++) checkVal("s5_sym", 32'(obsAll[i]), 32'(recQ[i]));
    checkVal("s5_lock_point", 32'(lockAt), 32'd6);

    // Reset while counting a candidate; the partial count must not survive.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i % 2 == 0) ? SYM_C : SYM_F);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i % 2 == 0) ? SYM_C : SYM_F);
    checkVal("s6_not_locked", 32'(o_locked), 32'd0);
    applyStimulus(1'b1, SYM_C);
    applyStimulus(1'b1, SYM_F);
    checkVal("s6_locked", 32'(o_locked), 32'd1);

    // Random words, commas of both disparities and random valid pattern.
    doReset();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [9:0] word;
      r = int'($urandom_range(99));
      if (r < 25) word = SYM_C;
      else if (r < 35) word = K28_5_RDP;
      else word = 10'($urandom);
      applyStimulus(int'($urandom_range(99)) < 70, word);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
